// File: rtl/aes_pkg.sv
// Shared types and helpers for the time-shared T-box AES round engine.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [4:0] CNT_DRAIN = 5'd16;

    // Rotate a 32-bit column right by n whole bytes (Te0 -> Te1..Te3).
    function automatic logic [31:0] rotr8(input logic [31:0] word, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = word;
            2'd1:    r = {word[7:0],  word[31:8]};
            2'd2:    r = {word[15:0], word[31:16]};
            default: r = {word[23:0], word[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_tbox_round_engine_te0box.sv
// Registered Te0 lookup: out = {2*S[x], S[x], S[x], 3*S[x]} one cycle after in.
// Bits [23:16] of the output are the plain S-box value.
module aes_tbox_round_engine_te0box (
    input  logic        clk,
    input  logic [7:0]  te_in,
    output logic [31:0] te_out
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0]  sb;
    logic [7:0]  sb2;
    logic [31:0] te_d;
    logic [31:0] te_q;

    always_comb begin
        sb   = SBOX[{~te_in, 3'b000} +: 8];
        sb2  = sb[7] ? ({sb[6:0], 1'b0} ^ 8'h1b) : {sb[6:0], 1'b0};
        te_d = {sb2, sb, sb, sb2 ^ sb};
    end

    always_ff @(posedge clk) begin
        te_q <= te_d;
    end

    assign te_out = te_q;

endmodule

// File: rtl/aes_tbox_round_engine.sv
// Iterative AES encryptor issuing one Te0 lookup per cycle, 17 cycles per round.
// state | meaning
// IDLE  | waiting for plaintext; in_ready high, rk_idx = 0
// ROUND | cnt 0..15 issue lookups, cnt 1..16 accumulate, cnt 16 commits round
// DONE  | ciphertext held on out_data with out_valid until out_ready
module aes_tbox_round_engine
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data
);

    localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [RKW-1:0] round_q, round_d;
    logic [127:0]   st_q, st_d;
    logic [31:0]    acc_q [4];
    logic [31:0]    acc_d [4];
    logic           out_valid_q, out_valid_d;
    logic [127:0]   out_data_q, out_data_d;

    logic [1:0]     issue_w;
    logic [7:0]     te_in;
    logic [31:0]    te_out;
    logic [3:0]     res_k;
    logic [1:0]     res_c;
    logic [1:0]     res_r;
    logic           last_round;
    logic [31:0]    rot;

    aes_tbox_round_engine_te0box u_te0box (
        .clk    (clk),
        .te_in  (te_in),
        .te_out (te_out)
    );

    // Issue: byte r of state word (c+r) mod 4; result for the previous issue.
    always_comb begin
        issue_w    = cnt_q[3:2] + cnt_q[1:0];
        te_in      = st_q[{~{issue_w, cnt_q[1:0]}, 3'b000} +: 8];
        res_k      = cnt_q[3:0] - 4'd1;
        res_c      = res_k[3:2];
        res_r      = res_k[1:0];
        last_round = (round_q == LAST_ROUND);
        rot        = last_round ? ({te_out[23:16], 24'h0} >> {res_r, 3'b000})
                                : rotr8(te_out, res_r);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        round_d     = round_q;
        st_d        = st_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data ^ rk_data;
                    round_d = RKW'(1);
                    cnt_d   = 5'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (cnt_q != 5'd0) begin
                    acc_d[res_c] = ((res_r == 2'd0) ? 32'h0 : acc_q[res_c]) ^ rot;
                end
                if (cnt_q == CNT_DRAIN) begin
                    // Column 3's last term is still in flight, fold it in directly.
                    st_d  = {acc_q[0] ^ rk_data[127:96],
                             acc_q[1] ^ rk_data[95:64],
                             acc_q[2] ^ rk_data[63:32],
                             acc_q[3] ^ rot ^ rk_data[31:0]};
                    cnt_d = 5'd0;
                    if (last_round) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = st_d;
                    end else begin
                        round_d = round_q + RKW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    round_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            round_q     <= '0;
            st_q        <= '0;
            acc_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            round_q     <= round_d;
            st_q        <= st_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign rk_idx    = (state_q == ROUND) ? round_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_tbox_round_engine.sv
// Scoreboard bench: textbook AES model (SubBytes/ShiftRows/MixColumns) supplies keys and expectations.
module tb_aes_tbox_round_engine;

    localparam int NR = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    aes_tbox_round_engine #(.NR(NR), .RKW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] exp_q[$];
    int           hs_q[$];
    int           last_hs;
    logic [7:0]   sbox_t [256];
    logic [127:0] rk_mem [NR+1];

    always_comb begin
        rk_data = '0;
        if (int'(rk_idx) <= NR) rk_data = rk_mem[rk_idx];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h0;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = pt ^ rk_mem[0];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
            for (int c = 0; c < 4; c++) begin
                if (r != NR) begin
                    s[4*c+0] = gmul(t[4*c],8'h2) ^ gmul(t[4*c+1],8'h3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h2) ^ gmul(t[4*c+2],8'h3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h2) ^ gmul(t[4*c+3],8'h3);
                    s[4*c+3] = gmul(t[4*c],8'h3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h2);
                end else begin
                    for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*c+rw];
                end
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
            blk ^= rk_mem[r];
        end
        return blk;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer pt until accepted; push the expected ciphertext at the handshake.
    task automatic send(input logic [127:0] pt, input logic [127:0] exp);
        bit ok = 0;
        in_data  = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (in_ready) begin
                exp_q.push_back(exp);
                hs_q.push_back(cyc);
                last_hs = cyc;
                ok = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (exp_q.size() == 0 && in_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    // Monitor: latency on each out_valid rise, ciphertext on each accepted output.
    initial begin
        bit ov_prev = 0;
        int h;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && !ov_prev) begin
                if (hs_q.size() > 0) begin
                    h = hs_q.pop_front();
                    chk("latency", 128'(cyc - h), 128'(1 + 17*NR));
                end else begin
                    fail_now("out_valid_without_accept");
                end
            end
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) chk("ciphertext", out_data, exp_q.pop_front());
                else fail_now("unexpected_output");
            end
        end
    end

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_ZZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] cap;
        logic [127:0] k;
        logic [127:0] p;
        int h1, h2, h3, h;
        bit seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        build_sbox();
        expand(K_C1);
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rk_idx", 128'(rk_idx), 128'd0);

        // FIPS-197 C.1 and B
        send(P_C1, C_C1);
        wait_drain();
        expand(K_B);
        send(P_B, C_B);
        wait_drain();

        // Zero vector with back-pressure on the output
        expand(128'h0);
        out_ready = 1'b0;
        send(128'h0, C_ZZ);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        if (!seen) fail_now("out_valid_timeout");
        cap = out_data;
        chk("held_data_value", cap, C_ZZ);
        repeat (20) begin
            @(negedge clk);
            chk("held_out_valid", 128'(out_valid), 128'd1);
            chk("held_out_data",  out_data,        cap);
            chk("held_in_ready",  128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back with in_valid held high, random key and plaintexts
        k = rnd128();
        expand(k);
        p = rnd128(); send(p, aes_enc(p)); h1 = last_hs;
        p = rnd128(); send(p, aes_enc(p)); h2 = last_hs;
        p = rnd128(); send(p, aes_enc(p)); h3 = last_hs;
        chk("b2b_spacing_1", 128'(h2 - h1), 128'(17*NR + 2));
        chk("b2b_spacing_2", 128'(h3 - h2), 128'(17*NR + 2));
        wait_drain();

        // Abort with reset at round 4, cnt 9
        expand(K_C1);
        send(P_C1, C_C1);
        h = last_hs;
        while (cyc < h + 1 + 3*17 + 9) @(negedge clk);
        chk("abort_rk_idx", 128'(rk_idx), 128'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        hs_q.delete();
        chk("abort_in_ready",  128'(in_ready),  128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_out_data",  out_data,        128'd0);
        send(P_C1, C_C1);
        wait_drain();

        // Ignored mid-round in_valid, rk_idx follows the round number
        chk("pre_rk_idx", 128'(rk_idx), 128'd0);
        send(P_C1, C_C1);
        for (int m = 0; m < 17*NR; m++) begin
            chk("rk_idx_track", 128'(rk_idx), 128'(1 + m/17));
            if (m == 30) begin
                in_data  = rnd128();
                in_valid = 1'b1;
            end
            if (m == 30) chk("busy_in_ready", 128'(in_ready), 128'd0);
            if (m == 34) in_valid = 1'b0;
            @(negedge clk);
        end
        wait_drain();

        // A few more random key/plaintext pairs
        repeat (2) begin
            k = rnd128();
            expand(k);
            p = rnd128();
            send(p, aes_enc(p));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
